adder_32_pipe: RTL and testbench
================================

Name: adder_32_pipe

Overview:
- Two-stage pipelined 32-bit adder built from two 16-bit carry-lookahead sections with valid/ready handshakes on input and output.
- Stage 1 adds the low 16 bits and registers the section carry c16. Stage 2 adds the high 16 bits using the registered c16 and produces the sum and flags.
- Sits between the operand-select logic and the ALU result mux.
- Full throughput of one operation per cycle; 2-cycle latency.

Parameters:
- DATA_W, 32, operand/result width. Fixed at two 16-bit sections; any other value is unsupported and is flagged by an elaboration-time check.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  stage 1 can accept
- a  in  32  operand A
- b  in  32  operand B
- cin  in  1  carry-in
- sub  in  1  subtract select (present only with ADDER32_SUB_EN)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  32  result
- cout  out  1  carry out of bit 31
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0. Stage-1 data registers are cleared to 0.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - in_ready = !s1_valid | s2_adv.
  - s2_adv = !out_valid | out_ready.
  - in_ready is combinational from out_ready; no other combinational in-to-out path.
- Operand preparation: b_eff = b, cin_eff = cin.
- Stage 1, loaded on input transfer:
  - Low section: lo = a[15:0] + b_eff[15:0] + cin_eff, computed as 4×4-bit groups with group P/G.
  - c16 = G_lo | (P_lo & cin_eff).
  - Registers: sum_lo, c16, a[31:16], b_eff[31:16], a[31], b_eff[31].
  - s1_valid is set on input transfer. It is cleared when stage 1 drains to stage 2 with no new input.
- Stage 2, loaded when s1_valid & s2_adv:
  - hi = a_hi + b_hi + c16.
  - sum = {hi, sum_lo}.
  - cout = G_hi | (P_hi & c16).
  - ovf = (a31 == b31_eff) & (sum[31] != a31).
  - zero = (sum == 0).
  - out_valid is set on load. It is cleared on output transfer with no new load.
- Output holding:
  - While out_valid & !out_ready, sum/cout/ovf/zero are held stable.
  - Stage 1 also holds; in_ready=0 once stage 1 is full.
- Simultaneous events:
  - Output transfer, stage-1 drain and input accept may all occur in the same cycle; no bubble is inserted.
  - Back-to-back operations produce results on consecutive cycles.
- Latency: input transfer in cycle N gives out_valid in cycle N+2, provided out_ready was high.
- Ordering: results are delivered in acceptance order. Nothing is dropped or duplicated under any out_ready pattern.
- Reset mid-operation: all in-flight operations are discarded and both valids are cleared on the next edge. in_ready=1 the cycle after rst deasserts.
- Wrap-around: 0xFFFFFFFF + 1 gives sum=0, cout=1, zero=1, ovf=0. There is no saturation.

Optional Feature:
- Macro: ADDER32_SUB_EN.
- Defined:
  - Port sub exists and is sampled with the operands.
  - When sub=1: b_eff = ~b and cin_eff = 1, so cin is ignored; ovf uses the inverted b[31].
  - When sub=0: behaves as add.
  - cout = 1 means no borrow.
- Undefined: port sub is absent; b_eff = b and cin_eff = cin always.

Test Plan:
- Reset, then a=0x0000FFFF, b=0x00000001, cin=0, out_ready=1 -> two cycles later sum=0x00010000, cout=0, ovf=0, zero=0 (c16 crosses stage boundary).
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, zero=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, cout=0. Also a=0x80000000, b=0x80000000 -> sum=0, ovf=1, cout=1.
- Stream 8 back-to-back ops while out_ready toggles 1,0,0,1,1,0,1,… -> results match in order with none lost; in_ready=0 exactly when both stages are full and out_ready=0; outputs stable while stalled.
- Assert rst with two ops in flight -> next cycle out_valid=0, sum=0, in_ready=1; no stale result ever appears.
- With ADDER32_SUB_EN, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. Also a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.

Source files
------------

// File: rtl/adder_32_pipe_if.sv
// Handshake/data bundle for adder_32_pipe.
// Optional macro ADDER32_SUB_EN adds the subtract-select signal 'sub'.
interface adder_32_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
`ifdef ADDER32_SUB_EN
    logic              sub;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              zero;

`ifdef ADDER32_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`endif
endinterface

// File: rtl/adder_32_pipe.sv
// Two-stage pipelined 32-bit adder: stage 1 adds the low 16 bits and
// registers the section carry c16, stage 2 adds the high 16 bits and
// produces sum/cout/ovf/zero. Valid/ready handshake on both sides,
// one operation per cycle, 2-cycle latency.
// Optional macro ADDER32_SUB_EN: adds 'sub' (b inverted, carry-in forced 1).
module adder_32_pipe #(
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    adder_32_pipe_if.slave  bus
);

    if (DATA_W != 32) begin : g_width_check
        $error("adder_32_pipe: DATA_W must be 32 (two 16-bit sections)");
    end

    typedef struct packed {
        logic [15:0] sum;
        logic        p;
        logic        g;
    } cla16_t;

    // 16-bit carry-lookahead section: four 4-bit groups with group P/G,
    // group carries derived from group P/G, section P/G exported.
    function automatic cla16_t cla16(input logic [15:0] x, input logic [15:0] y,
                                     input logic ci);
        logic [15:0] p;
        logic [15:0] g;
        logic [15:0] c;
        logic [3:0]  gp;
        logic [3:0]  gg;
        logic [4:0]  gc;
        cla16_t      r;
        p  = x ^ y;
        g  = x & y;
        gp = '0;
        gg = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc    = '0;
        gc[0] = ci;
        for (int unsigned k = 0; k < 4; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int unsigned i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        r.sum = p ^ c;
        r.p   = &gp;
        r.g   = gg[3]
              | (gp[3] & gg[2])
              | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
        return r;
    endfunction

    // Stage 1 registers
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] sum_lo_q,   sum_lo_d;
    logic        c16_q,      c16_d;
    logic [15:0] a_hi_q,     a_hi_d;
    logic [15:0] b_hi_q,     b_hi_d;
    logic        a31_q,      a31_d;
    logic        b31_q,      b31_d;
    // Stage 2 registers
    logic        out_valid_q, out_valid_d;
    logic [31:0] sum_q,       sum_d;
    logic        cout_q,      cout_d;
    logic        ovf_q,       ovf_d;
    logic        zero_q,      zero_d;

    logic [31:0] b_eff;
    logic        cin_eff;
    logic        s2_adv;
    logic        in_ready;
    logic        s1_load;
    logic        s2_load;
    cla16_t      lo_res;
    cla16_t      hi_res;
    logic [31:0] sum_full;

    // Operand preparation (subtract folds into b inversion and carry-in)
    always_comb begin
        b_eff   = bus.b;
        cin_eff = bus.cin;
`ifdef ADDER32_SUB_EN
        if (bus.sub) begin
            b_eff   = ~bus.b;
            cin_eff = 1'b1;
        end
`endif
    end

    // Handshake: in_ready looks through a free or draining stage 2
    always_comb begin
        s2_adv   = !out_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_adv;
        s1_load  = bus.in_valid && in_ready;
        s2_load  = s1_valid_q && s2_adv;
    end

    // Stage 1 next state: low-section add and capture of high operands
    always_comb begin
        lo_res     = cla16(bus.a[15:0], b_eff[15:0], cin_eff);
        s1_valid_d = s1_valid_q;
        sum_lo_d   = sum_lo_q;
        c16_d      = c16_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        a31_d      = a31_q;
        b31_d      = b31_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            sum_lo_d   = lo_res.sum;
            c16_d      = lo_res.g | (lo_res.p & cin_eff);
            a_hi_d     = bus.a[31:16];
            b_hi_d     = b_eff[31:16];
            a31_d      = bus.a[31];
            b31_d      = b_eff[31];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 next state: high-section add and flags, held while stalled
    always_comb begin
        hi_res      = cla16(a_hi_q, b_hi_q, c16_q);
        sum_full    = {hi_res.sum, sum_lo_q};
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            sum_d       = sum_full;
            cout_d      = hi_res.g | (hi_res.p & c16_q);
            ovf_d       = (a31_q == b31_q) && (sum_full[31] != a31_q);
            zero_d      = (sum_full == '0);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            sum_lo_q    <= '0;
            c16_q       <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            a31_q       <= 1'b0;
            b31_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            sum_lo_q    <= sum_lo_d;
            c16_q       <= c16_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            a31_q       <= a31_d;
            b31_q       <= b31_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_adder_32_pipe.sv
// Self-checking bench for adder_32_pipe: vector table, streaming with
// out_ready backpressure, and reset with operations in flight.
// Define ADDER32_SUB_EN to also exercise subtraction.
module tb_adder_32_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_32_pipe_if #(.DATA_W(32)) bus ();

    adder_32_pipe #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        res_t        r;
    } vec_t;

    res_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] bb;
        logic        ci;
        logic [32:0] t;
        res_t        r;
        bb = b;
        ci = cin;
`ifdef ADDER32_SUB_EN
        if (sub) begin
            bb = ~b;
            ci = 1'b1;
        end
`else
        if (sub) begin
        end
`endif
        t      = {1'b0, a} + {1'b0, bb} + {32'b0, ci};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
        r.zero = (t[31:0] == 32'h0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, evaluate transfers 1 ns later.
    task automatic cycle(input logic iv, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tcin, input logic tsub, input logic ordy,
                         input res_t e, output logic acc);
        res_t h;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ta;
        bus.b         = tb_;
        bus.cin       = tcin;
`ifdef ADDER32_SUB_EN
        bus.sub       = tsub;
`else
        if (tsub) begin
        end
`endif
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!(sb.size() == 2 && !ordy)));
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("stale_output", 32'(bus.out_valid), 32'd0);
            end else if (ordy) begin
                h = sb.pop_front();
                chk("sum",  bus.sum,        h.sum);
                chk("cout", 32'(bus.cout),  32'(h.cout));
                chk("ovf",  32'(bus.ovf),   32'(h.ovf));
                chk("zero", 32'(bus.zero),  32'(h.zero));
            end else begin
                h = sb[0];
                chk("stall_sum", bus.sum, h.sum);
            end
        end
        acc = iv && bus.in_ready;
        if (acc) sb.push_back(e);
    endtask

    vec_t        tbl[$];
    vec_t        v;
    res_t        nul;
    logic        acc;
    int          n;
    logic [31:0] sa[8];
    logic [31:0] sbv[8];
    logic        sc[8];
    logic        pat[8];
    int          sent;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nul = '{sum: 32'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        tbl.push_back('{a: 32'h0000FFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0, r: '{32'h00010000, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{a: 32'hFFFFFFFF, b: 32'h00000000, cin: 1'b1, sub: 1'b0, r: '{32'h00000000, 1'b1, 1'b0, 1'b1}});
        tbl.push_back('{a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0, r: '{32'h80000000, 1'b0, 1'b1, 1'b0}});
        tbl.push_back('{a: 32'h80000000, b: 32'h80000000, cin: 1'b0, sub: 1'b0, r: '{32'h00000000, 1'b1, 1'b1, 1'b1}});
        tbl.push_back('{a: 32'h12345678, b: 32'h87654321, cin: 1'b0, sub: 1'b0, r: '{32'h99999999, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{a: 32'h00000000, b: 32'h00000000, cin: 1'b0, sub: 1'b0, r: '{32'h00000000, 1'b0, 1'b0, 1'b1}});
        tbl.push_back('{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, cin: 1'b1, sub: 1'b0, r: '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}});
        tbl.push_back('{a: 32'h0000FFFF, b: 32'hFFFF0000, cin: 1'b1, sub: 1'b0, r: '{32'h00000000, 1'b1, 1'b0, 1'b1}});
`ifdef ADDER32_SUB_EN
        tbl.push_back('{a: 32'h00000005, b: 32'h00000007, cin: 1'b0, sub: 1'b1, r: '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{a: 32'h80000000, b: 32'h00000001, cin: 1'b0, sub: 1'b1, r: '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}});
        tbl.push_back('{a: 32'h00001234, b: 32'h00001234, cin: 1'b0, sub: 1'b1, r: '{32'h00000000, 1'b1, 1'b0, 1'b1}});
`endif

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef ADDER32_SUB_EN
        bus.sub       = 1'b0;
`endif
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       bus.sum,            32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd0);
        rst = 1'b0;

        // Table vectors, one at a time, with latency measurement
        foreach (tbl[i]) begin
            v = tbl[i];
            cycle(1'b1, v.a, v.b, v.cin, v.sub, 1'b1, v.r, acc);
            chk("accept", 32'(acc), 32'd1);
            n = 0;
            while (sb.size() != 0 && n < 10) begin
                cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, nul, acc);
                n++;
            end
            chk("latency", 32'(n), 32'd2);
        end

        // Back-to-back stream under out_ready backpressure
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            sa[i]  = $urandom;
            sbv[i] = $urandom;
            sc[i]  = 1'($urandom_range(0, 1));
        end
        sent = 0;
        n    = 0;
        while ((sent < 8 || sb.size() != 0) && n < 200) begin
            if (sent < 8)
                cycle(1'b1, sa[sent], sbv[sent], sc[sent], 1'b0, pat[n % 8],
                      model(sa[sent], sbv[sent], sc[sent], 1'b0), acc);
            else
                cycle(1'b0, '0, '0, 1'b0, 1'b0, pat[n % 8], nul, acc);
            if (acc) sent++;
            n++;
        end
        chk("stream_sent",    32'(sent),      32'd8);
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Reset with two operations in flight
        cycle(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0,
              model(32'h11111111, 32'h22222222, 1'b0, 1'b0), acc);
        cycle(1'b1, 32'h33333333, 32'h44444444, 1'b1, 1'b0, 1'b0,
              model(32'h33333333, 32'h44444444, 1'b1, 1'b0), acc);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum",       bus.sum,            32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        sb.delete();
        repeat (4) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, nul, acc);

        // Pipeline still usable after reset
        cycle(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1,
              '{32'h00000000, 1'b1, 1'b0, 1'b1}, acc);
        chk("post_rst_accept", 32'(acc), 32'd1);
        repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, nul, acc);
        chk("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
